// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath and the control FSM: bus source codes,
// load/inc/clear strobe bit indices and ALU op codes.
package datapath_pkg;

   localparam int CTRL_W = 16;

   typedef enum logic [3:0] {
      SRC_NONE = 4'd0,
      SRC_PC   = 4'd1,
      SRC_AR   = 4'd2,
      SRC_IR   = 4'd4,
      SRC_AC   = 4'd5,
      SRC_R    = 4'd6,
      SRC_R1   = 4'd7,
      SRC_R2   = 4'd8,
      SRC_R3   = 4'd9,
      SRC_R4   = 4'd10,
      SRC_DM   = 4'd12,
      SRC_IM   = 4'd13,
      SRC_AC2  = 4'd14
   } src_e;

   localparam int WB_PC  = 1;
   localparam int WB_AR  = 2;
   localparam int WB_IR  = 3;
   localparam int WB_AC  = 4;
   localparam int WB_R   = 5;
   localparam int WB_R4  = 7;
   localparam int WB_R3  = 8;
   localparam int WB_R2  = 9;
   localparam int WB_R1  = 10;
   localparam int WB_DM  = 11;
   localparam int WB_ALU = 12;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_MUL  = 3'd3,
      ALU_LSH  = 3'd4
   } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU; all results are unsigned and truncated to DATA_W bits.
module datapath_alu
   import datapath_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = a;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_MUL: y = a * b;
         ALU_LSH: y = a << 1;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/datapath_bus.sv
// Register-transfer datapath: PC/AR/IR/AC/R/R1-R4 around one shared bus,
// steered by the controller's read/write/inc/clr strobes.
module datapath_bus
   import datapath_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        read_en,
   input  logic [15:0]       write_en,
   input  logic [15:0]       inc_en,
   input  logic [15:0]       clr_en,
   input  logic [2:0]        alu_op,
   output logic [5:0]        instruction,
   output logic [15:0]       z,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [DATA_W-1:0] im_rdata,
   output logic [DATA_W-1:0] ac_out
);

   logic [DATA_W-1:0] pc, ar, ir, ac, r, r1, r2, r3, r4;
   logic [DATA_W-1:0] bus, alu_y;

   always_comb begin
      bus = '0;
      case (read_en)
         SRC_PC:          bus = pc;
         SRC_AR:          bus = ar;
         SRC_IR:          bus = ir;
         SRC_AC, SRC_AC2: bus = ac;
         SRC_R:           bus = r;
         SRC_R1:          bus = r1;
         SRC_R2:          bus = r2;
         SRC_R3:          bus = r3;
         SRC_R4:          bus = r4;
         SRC_DM:          bus = dm_rdata;
         SRC_IM:          bus = im_rdata;
         default:         bus = '0;
      endcase
   end

   datapath_alu #(.DATA_W(DATA_W)) u_alu (
      .a  (ac),
      .b  (r),
      .op (alu_op),
      .y  (alu_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
         ar <= '0;
         ir <= '0;
         r  <= '0;
         r1 <= '0;
         r2 <= '0;
         r3 <= '0;
         r4 <= '0;
      end else begin
         // a jump (bus load) overrides the sequential increment
         if (write_en[WB_PC])    pc <= bus;
         else if (inc_en[WB_PC]) pc <= pc + DATA_W'(1);
         if (write_en[WB_AR]) ar <= bus;
         if (write_en[WB_IR]) ir <= bus;
         if (write_en[WB_R])  r  <= bus;
         if (write_en[WB_R1]) r1 <= bus;
         if (write_en[WB_R2]) r2 <= bus;
         if (write_en[WB_R3]) r3 <= bus;
         if (write_en[WB_R4]) r4 <= bus;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  ac <= '0;
      else if (clr_en[WB_AC])      ac <= '0;
      else if (write_en[WB_ALU])   ac <= alu_y;
      else if (write_en[WB_AC])    ac <= bus;
      else if (inc_en[WB_AC])      ac <= ac + DATA_W'(1);
   end

   assign instruction = ir[5:0];
   assign z           = {15'b0, (ac == '0)};
   assign dm_addr     = ar[ADDR_W-1:0];
   assign im_addr     = pc[ADDR_W-1:0];
   assign dm_wdata    = bus;
   assign dm_we       = write_en[WB_DM];
   assign ac_out      = ac;

endmodule

// File: tb/tb_datapath_bus.sv
// Directed bench for datapath_bus: reset, fetch, load/store, ALU ops,
// strobe priorities and reset in the middle of a transfer.
module tb_datapath_bus;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  read_en;
   logic [15:0] write_en, inc_en, clr_en;
   logic [2:0]  alu_op;
   logic [5:0]  instruction;
   logic [15:0] z;
   logic [7:0]  dm_addr, im_addr;
   logic [15:0] dm_wdata, dm_rdata, im_rdata, ac_out;
   logic        dm_we;

   int tests = 0;
   int fails = 0;

   datapath_bus #(.DATA_W(16), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
      .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
      .instruction(instruction), .z(z), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
      .im_addr(im_addr), .im_rdata(im_rdata), .ac_out(ac_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      read_en = 4'd0; write_en = '0; inc_en = '0; clr_en = '0; alu_op = 3'd0;
   endtask

   // one edge, then settle 1ns past it and drop all strobes
   task automatic tick();
      @(posedge clk); #1;
      idle();
   endtask

   // bus <- im_rdata = v, load the registers selected by we
   task automatic load_im(input logic [15:0] v, input logic [15:0] we);
      im_rdata = v; read_en = 4'd13; write_en = we;
      tick();
   endtask

   initial begin
      idle();
      dm_rdata = '0; im_rdata = 16'hABCD;
      rst_n = 1'b0;
      // garbage strobes clocked while in reset
      read_en = 4'd13; write_en = 16'hFFFF; inc_en = 16'hFFFF; alu_op = 3'd3;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ac", ac_out, 16'h0000);
      chk("rst_z", z, 16'h0001);
      chk("rst_instr", instruction, 6'd0);
      chk("rst_im_addr", im_addr, 8'd0);
      chk("rst_dm_addr", dm_addr, 8'd0);
      idle();
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_ac", ac_out, 16'h0000);
      read_en = 4'd6; #1;
      chk("post_rst_r", dm_wdata, 16'h0000);
      read_en = 4'd10; #1;
      chk("post_rst_r4", dm_wdata, 16'h0000);
      idle();

      // fetch
      load_im(16'h0013, 16'h0008);
      chk("fetch_instr", instruction, 6'd19);
      chk("fetch_pc_hold", im_addr, 8'd0);
      inc_en = 16'h0002; tick();
      chk("pc_inc", im_addr, 8'd1);
      read_en = 4'd1; #1;
      chk("bus_pc", dm_wdata, 16'h0001);
      idle();

      // load / store
      load_im(16'h0005, 16'h0004);
      chk("ar_load", dm_addr, 8'd5);
      read_en = 4'd2; #1;
      chk("bus_ar", dm_wdata, 16'h0005);
      dm_rdata = 16'h1234; read_en = 4'd12; write_en = 16'h0010;
      tick();
      chk("ac_from_dm", ac_out, 16'h1234);
      chk("z_nonzero", z, 16'h0000);
      read_en = 4'd5; write_en = 16'h0800; #1;
      chk("st_we", dm_we, 1'b1);
      chk("st_wdata", dm_wdata, 16'h1234);
      chk("st_addr", dm_addr, 8'd5);
      tick();
      chk("we_drop", dm_we, 1'b0);
      read_en = 4'd14; #1;
      chk("bus_ac14", dm_wdata, 16'h1234);
      read_en = 4'd11; #1;
      chk("bus_unused", dm_wdata, 16'h0000);
      idle();

      // R1-R4 strobe mapping
      load_im(16'h1111, 16'h0400);
      load_im(16'h2222, 16'h0200);
      load_im(16'h3333, 16'h0100);
      load_im(16'h4444, 16'h0080);
      read_en = 4'd7;  #1; chk("r1", dm_wdata, 16'h1111);
      read_en = 4'd8;  #1; chk("r2", dm_wdata, 16'h2222);
      read_en = 4'd9;  #1; chk("r3", dm_wdata, 16'h3333);
      read_en = 4'd10; #1; chk("r4", dm_wdata, 16'h4444);
      idle();

      // ALU
      load_im(16'h0003, 16'h0010);
      load_im(16'h0005, 16'h0020);
      alu_op = 3'd2; write_en = 16'h1000; tick();
      chk("alu_sub_wrap", ac_out, 16'hFFFE);
      load_im(16'h0002, 16'h0020);
      alu_op = 3'd3; write_en = 16'h1000; tick();
      chk("alu_mul", ac_out, 16'hFFFC);
      alu_op = 3'd4; write_en = 16'h1000; tick();
      chk("alu_lsh", ac_out, 16'hFFF8);
      load_im(16'hFFFF, 16'h0010);
      inc_en = 16'h0010; tick();
      chk("ac_inc_wrap", ac_out, 16'h0000);
      chk("z_set", z, 16'h0001);
      alu_op = 3'd1; write_en = 16'h1000; tick();
      chk("alu_add", ac_out, 16'h0002);
      alu_op = 3'd6; write_en = 16'h1000; tick();
      chk("alu_pass6", ac_out, 16'h0002);

      // priorities
      clr_en = 16'h0010; write_en = 16'h1000; inc_en = 16'h0010; alu_op = 3'd1;
      tick();
      chk("prio_clr", ac_out, 16'h0000);
      im_rdata = 16'h0055; read_en = 4'd13; write_en = 16'h1010; alu_op = 3'd1;
      tick();
      chk("prio_alu_over_bus", ac_out, 16'h0002);
      load_im(16'h0007, 16'h0008);
      read_en = 4'd4; write_en = 16'h0002; inc_en = 16'h0002; tick();
      chk("prio_jump", im_addr, 8'd7);

      // reset between AR load and AC load
      load_im(16'h0009, 16'h0004);
      chk("mid_ar", dm_addr, 8'd9);
      dm_rdata = 16'h4444; read_en = 4'd12; write_en = 16'h0010;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ac", ac_out, 16'h0000);
      chk("mid_rst_ar", dm_addr, 8'd0);
      @(posedge clk); #1;
      idle();
      #2 rst_n = 1'b1;
      tick();
      chk("mid_ac_after", ac_out, 16'h0000);
      chk("mid_no_we", dm_we, 1'b0);
      chk("mid_pc", im_addr, 8'd0);
      load_im(16'h0042, 16'h0010);
      chk("first_load_after", ac_out, 16'h0042);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/datapath_bus.md
# datapath_bus

Register-transfer datapath driven by the processor control FSM. Holds PC, AR, IR, AC, R, R1–R4, a shared 16-bit bus, the ALU and the data/instruction memory ports. Decodes the controller's `read_en`, `write_en`, `inc_en`, `clr_en` and `alu_op` codes. Returns `instruction` and the zero flag `z` to the controller.

## Interface
- `DATA_W`, 16: width of bus, registers and memory words.
- `ADDR_W`, 8: memory address width; `dm_addr`/`im_addr` are the low `ADDR_W` bits of AR/PC.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `read_en` in 4: bus source code. 1 PC, 2 AR, 4 IR, 5 AC, 6 R, 7 R1, 8 R2, 9 R3, 10 R4, 12 DM, 13 IM, 14 AC. 0 and all other codes drive the bus to 0.
- `write_en` in 16: one-hot load strobes. bit1 PC, bit2 AR, bit3 IR, bit4 AC (from bus), bit5 R, bit7 R4, bit8 R3, bit9 R2, bit10 R1, bit11 DM write, bit12 AC←ALU. Other bits are ignored.
- `inc_en` in 16: bit1 PC+1, bit4 AC+1. Others ignored.
- `clr_en` in 16: bit4 AC←0. Others ignored.
- `alu_op` in 3: 0 pass AC, 1 AC+R, 2 AC−R, 3 AC×R (low `DATA_W` bits), 4 AC<<1. 5–7 behave as pass.
- `instruction` out 6: IR[5:0].
- `z` out 16: bit0 = (AC == 0); bits 15:1 are always 0.
- `dm_addr` out `ADDR_W`: AR[`ADDR_W`-1:0].
- `dm_wdata` out `DATA_W`: bus value.
- `dm_we` out 1: write_en[11].
- `dm_rdata` in `DATA_W`: data memory read data, combinational read of `dm_addr`.
- `im_addr` out `ADDR_W`: PC[`ADDR_W`-1:0].
- `im_rdata` in `DATA_W`: instruction memory read data, combinational read of `im_addr`.
- `ac_out` out `DATA_W`: AC, for debug/result observation.

## Operation
- Bus is combinational: `bus = mux(read_en)` over the register outputs, `dm_rdata` and `im_rdata`.
- Any number of registers may load from the bus in the same cycle.
- AC next-value priority: `clr_en[4]` > `write_en[12]` (ALU) > `write_en[4]` (bus) > `inc_en[4]` > hold.
- PC next-value priority: `write_en[1]` (bus) > `inc_en[1]` > hold.
- All arithmetic is unsigned, modulo 2^`DATA_W`:
  - AC+1 at 0xFFFF wraps to 0.
  - AC−R with R > AC wraps.
  - PC+1 wraps at 2^`DATA_W`.
- ALU reads the current AC and R values. The result lands in AC at the next edge.
- `z` and `instruction` are combinational from the registered AC/IR and carry no extra latency.
- `dm_we` is a pure pass-through of write_en[11]. The memory writes `dm_wdata` at `dm_addr` on the same edge.
- Reset (`rst_n` = 0), asynchronously and regardless of clock:
  - PC, AR, IR, AC, R and R1–R4 go to 0.
  - Therefore `instruction` = 0, `z` = 16'h0001, `im_addr` = 0, `dm_addr` = 0, `ac_out` = 0.
  - `dm_we` follows its input; the controller holds it 0 in its start state.
- Reset asserted mid-transfer discards the pending load. The first edge after release performs normal loads.

## Timing
- Every register transfer takes one cycle: source selected in cycle n, destination updated at the rising edge ending cycle n.
- A value written in cycle n is readable on the bus in cycle n+1. There is no bypass within a cycle.
- Fetch: PC→`im_addr`, `read_en`=13 with `write_en[3]` loads IR at that edge. `instruction` is valid in the following cycle, so the controller can dispatch in its fetch2 state.
- Load sequence: AR is loaded in cycle n, `dm_rdata` is assumed stable in cycle n+1, AC loads at the end of cycle n+1.
- Simultaneous events:
  - `write_en[12]` with `write_en[4]`: the ALU result wins.
  - `clr_en[4]` with any AC load: AC becomes 0.
  - `write_en[1]` with `inc_en[1]`: PC takes the bus value (jump wins).

## Structure
- Package `datapath_pkg` holds:
  - `read_en` source codes (SRC_PC … SRC_IM).
  - `write_en`/`inc_en`/`clr_en` bit indices (WB_PC, WB_AR, WB_IR, WB_AC, WB_R, WB_R1–WB_R4, WB_DM, WB_ALU).
  - ALU op codes (ALU_PASS, ALU_ADD, ALU_SUB, ALU_MUL, ALU_LSH).
  - The control FSM imports the same package.
- Sub-module `datapath_alu`: combinational, with inputs `a`, `b`, `op` and output `y`. Registers and the bus mux stay in the top level.

## Test plan
- Reset: release `rst_n` after clocking garbage strobes -> all registers 0, `z` = 16'h0001, `instruction` = 0.
- Fetch: `im_rdata` = 16'h0013, `read_en` = 13, `write_en[3]` = 1 for one cycle -> `instruction` = 6'd19 next cycle; PC unchanged until `inc_en[1]`.
- Load/store: AR←0x0005; `dm_rdata` = 0x1234 with `read_en` = 12, `write_en[4]` -> AC = 0x1234. Then `read_en` = 5, `write_en[11]` -> `dm_we` = 1, `dm_wdata` = 0x1234, `dm_addr` = 5.
- ALU: AC = 3, R = 5.
  - op 2 -> AC = 0xFFFE.
  - Then R = 2, op 3 -> AC = 0xFFFC.
  - op 4 -> AC = 0xFFF8.
  - AC = 0xFFFF with `inc_en[4]` -> AC = 0, `z[0]` = 1.
- Priorities:
  - `clr_en[4]` + `write_en[12]` + `inc_en[4]` together -> AC = 0.
  - `write_en[1]` with IR on the bus (0x0007) + `inc_en[1]` -> PC = 7.
- Mid-operation reset: assert `rst_n` low between AR load and AC load -> AC stays 0 after release; no spurious `dm_we`.
